dequant_luma4: RTL

- Inverse of the level-cost path: converts one 4x4 block of quantized luma levels back into dequantized transform coefficients (coeff = level × step) for the reconstruction/IDCT stage.
- Processes LANES_PER_CYCLE coefficients per clock under a start/busy/done handshake.
- Also reports the last non-zero position in zigzag order, for the token/cost stages.

---
 rtl/dequant_luma4.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dequant_luma4.sv
// dequant_luma4: dequantizes one 4x4 block of luma levels (coeff = level * step,
// saturated to the lane width), LANES_PER_CYCLE lanes per RUN cycle, and reports
// the highest zigzag index holding a non-zero level.
module dequant_luma4 #(
  parameter int BIT_WIDTH       = 16,
  parameter int BLOCK_SIZE      = 4,
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BIT_WIDTH*16-1:0] levels,
  input  logic [15:0]            q_dc,
  input  logic [15:0]            q_ac,
  output logic [BIT_WIDTH*16-1:0] coeffs,
  output logic [4:0]             last,
  output logic                   busy,
  output logic                   done
);

  // Block edge is fixed at 4; LANES_PER_CYCLE must divide 16 (1, 2, 4, 8, 16).
  localparam int NUM_LANES = BLOCK_SIZE * BLOCK_SIZE;
  localparam int NUM_STEPS = NUM_LANES / LANES_PER_CYCLE;
  // Wide enough for any signed level times a zero-extended 16-bit step.
  localparam int PROD_W    = BIT_WIDTH + 17;
  localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (BIT_WIDTH - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam int ZZ [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state_reg, state_next;
  logic [3:0]                 cnt_reg, cnt_next;
  logic [BIT_WIDTH*16-1:0]    lvl_reg;
  logic [15:0]                q_dc_reg, q_ac_reg;
  logic                       capture_en;

  logic [BIT_WIDTH*16-1:0]    coeffs_next;
  logic [4:0]                 last_next;
  logic                       busy_next, done_next;

  logic [BIT_WIDTH*16-1:0]    lane_vals;
  logic [NUM_LANES-1:0]       lane_we;
  logic [NUM_LANES-1:0]       nz;
  logic [NUM_LANES-1:0]       nz_zz;
  logic [4:0]                 last_calc;

  // Per-lane multiply, saturation, write enable and non-zero flag.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [15:0]               q_lane;
    logic signed [PROD_W-1:0]  lvl_ext, q_ext, prod;

    if (gi == 0) begin : g_dc
      assign q_lane = q_dc_reg;
    end else begin : g_ac
      assign q_lane = q_ac_reg;
    end

    assign lvl_ext = PROD_W'($signed(lvl_reg[gi*BIT_WIDTH +: BIT_WIDTH]));
    assign q_ext   = PROD_W'(q_lane);
    assign prod    = lvl_ext * q_ext;

    assign lane_vals[gi*BIT_WIDTH +: BIT_WIDTH] =
        (prod > SAT_MAX) ? {1'b0, {(BIT_WIDTH-1){1'b1}}} :
        (prod < SAT_MIN) ? {1'b1, {(BIT_WIDTH-1){1'b0}}} :
                           prod[BIT_WIDTH-1:0];

    assign lane_we[gi] = (state_reg == RUN) && (cnt_reg == 4'(gi / LANES_PER_CYCLE));
    assign nz[gi]      = |lvl_reg[gi*BIT_WIDTH +: BIT_WIDTH];
    // Non-zero flags reordered into zigzag scan order.
    assign nz_zz[gi]   = nz[ZZ[gi]];
  end

  // Highest zigzag position with a non-zero captured level (0x1F when none).
  always_comb begin
    last_calc = 5'h1F;
    for (int z = 0; z < NUM_LANES; z++) begin
      if (nz_zz[z]) last_calc = 5'(z);
    end
  end

  // Next-state and output logic for the IDLE/RUN controller.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    coeffs_next = coeffs;
    last_next   = last;
    busy_next   = busy;
    done_next   = 1'b0;
    capture_en  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          capture_en  = 1'b1;
          coeffs_next = '0;
          busy_next   = 1'b1;
          cnt_next    = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_we[i]) coeffs_next[i*BIT_WIDTH +: BIT_WIDTH] = lane_vals[i*BIT_WIDTH +: BIT_WIDTH];
        end
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == LAST_STEP) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          last_next  = last_calc;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Controller state and block outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      coeffs    <= '0;
      last      <= 5'h1F;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      coeffs    <= coeffs_next;
      last      <= last_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Snapshot of the inputs taken when a block is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_reg  <= '0;
      q_dc_reg <= '0;
      q_ac_reg <= '0;
    end else if (capture_en) begin
      lvl_reg  <= levels;
      q_dc_reg <= q_dc;
      q_ac_reg <= q_ac;
    end
  end

endmodule
